alu19_issue_stage: RTL and testbench

Issue stage directly upstream of the 19-bit combinational ALU. It accepts operation commands (opcode plus two operands) over a valid/ready handshake and buffers them in a small FIFO. It drives the ALU's `A`/`B`/`opcode` inputs from registers held stable for a fixed number of cycles, then captures the ALU result into an output register. That register is presented downstream with its own valid/ready handshake, together with status flags.

---
 rtl/alu19_issue_stage.sv | 231 +++++++++++++++++++++++
 tb/tb_alu19_issue_stage.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu19_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module   : alu19_issue_stage
//  Purpose  : Issue stage in front of a 19-bit combinational ALU. Buffers
//             commands in a small FIFO, holds ALU operands stable for the
//             opcode's latency, captures the result and flags, and presents
//             them downstream over a valid/ready handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module alu19_issue_stage #(
    parameter int DEPTH   = 4,
    parameter int DIV_LAT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_opcode,
    input  logic [18:0] in_a,
    input  logic [18:0] in_b,
    output logic [18:0] alu_a,
    output logic [18:0] alu_b,
    output logic [4:0]  alu_opcode,
    input  logic [18:0] alu_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [18:0] out_result,
    output logic [4:0]  out_opcode,
    output logic        out_zero,
    output logic        out_div0,
    output logic        out_illegal
);

    localparam int         PTR_W   = $clog2(DEPTH);
    localparam int         CNT_W   = PTR_W + 1;
    localparam int         WCNT_W  = $clog2(DIV_LAT + 1);
    localparam int         ENTRY_W = 5 + 19 + 19;
    localparam logic [4:0] OP_DIV  = 5'b00011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [ENTRY_W-1:0]   mem_q [DEPTH];
    logic [ENTRY_W-1:0]   mem_d [DEPTH];
    logic [WCNT_W-1:0]    wcnt_q, wcnt_d;
    logic [18:0]          alu_a_q, alu_a_d;
    logic [18:0]          alu_b_q, alu_b_d;
    logic [4:0]           alu_opcode_q, alu_opcode_d;
    logic [18:0]          out_result_q, out_result_d;
    logic [4:0]           out_opcode_q, out_opcode_d;
    logic                 out_zero_q, out_zero_d;
    logic                 out_div0_q, out_div0_d;
    logic                 out_illegal_q, out_illegal_d;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_capture;
    logic                 w_empty;
    logic [ENTRY_W-1:0]   w_head;
    logic                 w_is_div;
    logic                 w_illegal;
    logic                 w_div0;
    logic [18:0]          w_cap_result;

    // Handshake and opcode decode; in_ready depends on occupancy only, so a
    // pop on the same edge never makes room for a push into a full FIFO.
    always_comb begin
        in_ready  = (count_q != CNT_W'(DEPTH));
        w_push    = in_valid && in_ready;
        w_empty   = (count_q == '0);
        w_head    = mem_q[rd_ptr_q];
        w_is_div  = (alu_opcode_q == OP_DIV);
        w_illegal = !((alu_opcode_q <= 5'b01110) ||
                      ((alu_opcode_q >= 5'b10001) && (alu_opcode_q <= 5'b10011)));
        w_div0    = w_is_div && (alu_b_q == '0);
        if (w_div0) begin
            w_cap_result = 19'h7FFFF;
        end else if (w_illegal) begin
            w_cap_result = '0;
        end else begin
            w_cap_result = alu_result;
        end
    end

    // Sequencer: pop into the ALU operand registers, wait out the divide
    // latency, capture, then hold until the result is taken downstream.
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        w_pop     = 1'b0;
        w_capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (!w_empty) begin
                    w_pop   = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (!w_is_div || (DIV_LAT == 1)) begin
                    w_capture = 1'b1;
                    state_d   = HOLD;
                end else begin
                    wcnt_d  = WCNT_W'(DIV_LAT - 2);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (wcnt_q == '0) begin
                    w_capture = 1'b1;
                    state_d   = HOLD;
                end else begin
                    wcnt_d = wcnt_q - WCNT_W'(1);
                end
            end
            HOLD: begin
                if (out_ready) begin
                    if (!w_empty) begin
                        w_pop   = 1'b1;
                        state_d = EXEC;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO storage, pointers and occupancy; pointers wrap naturally since
    // DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) begin
            mem_d[wr_ptr_q] = {in_opcode, in_a, in_b};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Operand registers load only on a pop; output registers only on capture.
    always_comb begin
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_opcode_d  = alu_opcode_q;
        out_result_d  = out_result_q;
        out_opcode_d  = out_opcode_q;
        out_zero_d    = out_zero_q;
        out_div0_d    = out_div0_q;
        out_illegal_d = out_illegal_q;
        if (w_pop) begin
            alu_opcode_d = w_head[42:38];
            alu_a_d      = w_head[37:19];
            alu_b_d      = w_head[18:0];
        end
        if (w_capture) begin
            out_result_d  = w_cap_result;
            out_opcode_d  = alu_opcode_q;
            out_zero_d    = (w_cap_result == '0);
            out_div0_d    = w_div0;
            out_illegal_d = w_illegal;
        end
    end

    // State register; reset discards queued and in-flight commands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            wcnt_q        <= '0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_opcode_q  <= '0;
            out_result_q  <= '0;
            out_opcode_q  <= '0;
            out_zero_q    <= 1'b0;
            out_div0_q    <= 1'b0;
            out_illegal_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            wcnt_q        <= wcnt_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_opcode_q  <= alu_opcode_d;
            out_result_q  <= out_result_d;
            out_opcode_q  <= out_opcode_d;
            out_zero_q    <= out_zero_d;
            out_div0_q    <= out_div0_d;
            out_illegal_q <= out_illegal_d;
            mem_q         <= mem_d;
        end
    end

    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_opcode  = alu_opcode_q;
    assign out_valid   = (state_q == HOLD);
    assign out_result  = out_result_q;
    assign out_opcode  = out_opcode_q;
    assign out_zero    = out_zero_q;
    assign out_div0    = out_div0_q;
    assign out_illegal = out_illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_alu19_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu19_issue_stage
//  Purpose  : Directed self-checking bench for alu19_issue_stage with a small
//             stand-in ALU (ADD, SUB, DIV, XOR; other opcodes return A+1).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu19_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_opcode;
    logic [18:0] in_a;
    logic [18:0] in_b;
    logic [18:0] alu_a;
    logic [18:0] alu_b;
    logic [4:0]  alu_opcode;
    logic [18:0] alu_result;
    logic        out_valid;
    logic        out_ready;
    logic [18:0] out_result;
    logic [4:0]  out_opcode;
    logic        out_zero;
    logic        out_div0;
    logic        out_illegal;

    int n_tests = 0;
    int n_fail  = 0;

    alu19_issue_stage #(.DEPTH(4), .DIV_LAT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_a(in_a), .in_b(in_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_result(alu_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_opcode(out_opcode),
        .out_zero(out_zero), .out_div0(out_div0), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    // Stand-in combinational ALU
    always_comb begin
        case (alu_opcode)
            5'b00000: alu_result = alu_a + alu_b;
            5'b00001: alu_result = alu_a - alu_b;
            5'b00011: alu_result = (alu_b != 0) ? (alu_a / alu_b) : 19'd0;
            5'b00110: alu_result = alu_a ^ alu_b;
            default:  alu_result = alu_a + 19'd1;
        endcase
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one command and return once it is accepted (bounded).
    task automatic push(input logic [4:0] op, input logic [18:0] a, input logic [18:0] b);
        logic ok;
        ok        = 1'b0;
        in_valid  = 1'b1;
        in_opcode = op;
        in_a      = a;
        in_b      = b;
        for (int i = 0; i < 20; i++) begin
            ok = in_ready;
            tick();
            if (ok) break;
        end
        in_valid = 1'b0;
        check_eq("push_accepted", {31'd0, ok}, 32'd1);
    endtask

    // Count cycles from the accept edge until out_valid rises (bounded).
    task automatic wait_valid(input string tag, input int exp_lat);
        int lat;
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        check_eq(tag, lat, exp_lat);
    endtask

    logic [18:0] exp_q [5];
    int          got_n;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_opcode = '0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        repeat (3) tick();

        // Reset state
        check_eq("rst_in_ready",  {31'd0, in_ready}, 32'd1);
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_out_result", {13'd0, out_result}, 32'd0);
        check_eq("rst_alu_a", {13'd0, alu_a}, 32'd0);
        check_eq("rst_flags", {27'd0, out_opcode, out_zero, out_div0, out_illegal}, 32'd0);
        rst_n = 1'b1;
        tick();

        // ADD 5+7 = 12, valid two cycles after accept
        out_ready = 1'b1;
        push(5'b00000, 19'd5, 19'd7);
        check_eq("add_alu_a_pre", {13'd0, alu_a}, 32'd0);
        wait_valid("add_latency", 2);
        check_eq("add_result", {13'd0, out_result}, 32'd12);
        check_eq("add_zero", {31'd0, out_zero}, 32'd0);
        check_eq("add_opcode", {27'd0, out_opcode}, 32'd0);
        tick();
        check_eq("add_consumed", {31'd0, out_valid}, 32'd0);

        // DIV 100/0 -> saturated result, div0 flag
        push(5'b00011, 19'd100, 19'd0);
        wait_valid("div0_latency", 5);
        check_eq("div0_result", {13'd0, out_result}, 32'h7FFFF);
        check_eq("div0_flag", {31'd0, out_div0}, 32'd1);
        check_eq("div0_zero", {31'd0, out_zero}, 32'd0);
        tick();

        // DIV 100/7 = 14 at accept+5
        push(5'b00011, 19'd100, 19'd7);
        wait_valid("div_latency", 5);
        check_eq("div_result", {13'd0, out_result}, 32'd14);
        check_eq("div_flag", {31'd0, out_div0}, 32'd0);
        check_eq("div_alu_b_held", {13'd0, alu_b}, 32'd7);
        tick();

        // Illegal opcode 10100 -> result 0, illegal, zero
        push(5'b10100, 19'd3, 19'd0);
        wait_valid("ill_latency", 2);
        check_eq("ill_result", {13'd0, out_result}, 32'd0);
        check_eq("ill_flag", {31'd0, out_illegal}, 32'd1);
        check_eq("ill_zero", {31'd0, out_zero}, 32'd1);
        tick();

        // Boundary illegal 01111, boundary legal 10001
        push(5'b01111, 19'd3, 19'd0);
        wait_valid("ill2_latency", 2);
        check_eq("ill2_flag", {31'd0, out_illegal}, 32'd1);
        tick();
        push(5'b10001, 19'd3, 19'd0);
        wait_valid("leg_latency", 2);
        check_eq("leg_flag", {31'd0, out_illegal}, 32'd0);
        check_eq("leg_result", {13'd0, out_result}, 32'd4);
        check_eq("leg_opcode", {27'd0, out_opcode}, 32'h11);
        tick();

        // SUB 0-1 wraps; XOR equal operands is zero
        push(5'b00001, 19'd0, 19'd1);
        wait_valid("sub_latency", 2);
        check_eq("sub_result", {13'd0, out_result}, 32'h7FFFF);
        check_eq("sub_zero", {31'd0, out_zero}, 32'd0);
        tick();
        push(5'b00110, 19'h2AAAA, 19'h2AAAA);
        wait_valid("xor_latency", 2);
        check_eq("xor_result", {13'd0, out_result}, 32'd0);
        check_eq("xor_zero", {31'd0, out_zero}, 32'd1);
        check_eq("xor_illegal", {31'd0, out_illegal}, 32'd0);
        tick();

        // Backpressure: 4 queued + 1 in flight fills the stage
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push(5'b00000, 19'(i + 1), 19'd100);
            exp_q[i] = 19'(101 + i);
        end
        check_eq("full_in_ready", {31'd0, in_ready}, 32'd0);
        check_eq("full_out_valid", {31'd0, out_valid}, 32'd1);
        check_eq("full_first", {13'd0, out_result}, 32'd101);
        // A push offered while full is dropped even though a pop happens now
        in_valid  = 1'b1;
        in_opcode = 5'b00000;
        in_a      = 19'd600;
        in_b      = 19'd0;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check_eq("after_pop_in_ready", {31'd0, in_ready}, 32'd1);
        got_n = 1;
        for (int c = 0; c < 40; c++) begin
            if (out_valid) begin
                if (got_n < 5) begin
                    check_eq("drain_order", {13'd0, out_result}, {13'd0, exp_q[got_n]});
                end
                got_n++;
            end
            tick();
        end
        check_eq("drain_count", got_n, 5);

        // Reset during WAIT with two entries queued
        push(5'b00011, 19'd100, 19'd7);
        push(5'b00000, 19'd1, 19'd1);
        push(5'b00000, 19'd2, 19'd2);
        check_eq("pre_rst_valid", {31'd0, out_valid}, 32'd0);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        check_eq("mid_rst_alu_b", {13'd0, alu_b}, 32'd0);
        tick();
        rst_n = 1'b1;
        got_n = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (out_valid) got_n++;
        end
        check_eq("post_rst_no_result", got_n, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
